bcd_scan_ctrl: RTL and testbench



---
 rtl/bcd_scan_pkg.sv | 19 +
 rtl/bcd_scan_timer.sv | 29 ++
 rtl/bcd_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_scan_pkg.sv
// Shared types, widths and helpers for the BCD display scan controller.
package bcd_scan_pkg;

  localparam int BIN_W = 6;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CAPT,
    HOLD
  } state_t;

  // Each channel owns two consecutive slots: units (even) then tens (odd).
  function automatic int unsigned slot_to_channel(input int unsigned slot);
    return slot >> 1;
  endfunction

endpackage

// File: rtl/bcd_scan_timer.sv
// Per-slot hold timer: counts 0..HOLD_CYC-1 while run is high, tc marks the last cycle.
module bcd_scan_timer #(
  parameter int HOLD_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tc
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tc = run && (cnt_q == LAST);

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed 7-segment scan scheduler sharing one external binary-to-BCD converter.
// Optional leading-zero blanking of tens digits is enabled by defining BCD_SCAN_LZB_EN.
module bcd_scan_ctrl
  import bcd_scan_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int HOLD_CYC      = 50000,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [BIN_W*NUM_CH-1:0] val_flat,
  output logic [BIN_W-1:0]        conv_bin,
  input  logic [BCD_W-1:0]        conv_tens,
  input  logic [BCD_W-1:0]        conv_units,
  output logic [2*NUM_CH-1:0]     an,
  output logic [BCD_W-1:0]        digit,
  output logic                    frame_done
);

  localparam int AN_W   = 2 * NUM_CH;
  localparam int SLOT_W = (AN_W > 2) ? $clog2(AN_W) : 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(AN_W - 1);
  localparam logic [AN_W-1:0]   AN_OFF    = (AN_ACTIVE_LOW != 0) ? {AN_W{1'b1}} : {AN_W{1'b0}};

  // Registered state is kept in named signals so checkers can bind to it.
  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [BIN_W-1:0]  snap_q [NUM_CH];
  logic [BIN_W-1:0]  conv_q, conv_d;
  logic [BCD_W-1:0]  digit_q, digit_d;
  logic [AN_W-1:0]   an_q, an_d;
  logic              frame_q, frame_d;
  logic              snap_load;
  logic              lit_d;
  logic [AN_W-1:0]   onehot_d;
  logic [CH_W-1:0]   ch_idx;
  logic              hold_tc;

  assign ch_idx = CH_W'(slot_to_channel(32'(slot_q)));

  bcd_scan_timer #(
    .HOLD_CYC (HOLD_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == CAPT),
    .run   (state_q == HOLD),
    .tc    (hold_tc)
  );

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    conv_d    = conv_q;
    digit_d   = digit_q;
    frame_d   = 1'b0;
    snap_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          snap_load = 1'b1;
          slot_d    = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        conv_d  = snap_q[ch_idx];
        state_d = CAPT;
      end
      CAPT: begin
        // conv_bin has been stable for a full cycle, so the converter output is settled.
        digit_d = slot_q[0] ? conv_tens : conv_units;
        state_d = HOLD;
      end
      HOLD: begin
        if (hold_tc) begin
          if (!en) begin
            state_d = IDLE;
          end else if (slot_q == LAST_SLOT) begin
            frame_d   = 1'b1;
            snap_load = 1'b1;
            slot_d    = '0;
            state_d   = LOAD;
          end else begin
            slot_d  = slot_q + SLOT_W'(1);
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Anodes are decoded from next state so the pins come straight from flops.
    lit_d = (state_d == HOLD);
`ifdef BCD_SCAN_LZB_EN
    if (slot_d[0] && (digit_d == '0)) begin
      lit_d = 1'b0;
    end
`endif
    onehot_d = lit_d ? (AN_W'(1) << slot_d) : '0;
    an_d     = (AN_ACTIVE_LOW != 0) ? ~onehot_d : onehot_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      conv_q  <= '0;
      digit_q <= '0;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        snap_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      conv_q  <= conv_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      frame_q <= frame_d;
      // One snapshot per frame keeps tens and units of a channel coherent.
      if (snap_load) begin
        for (int c = 0; c < NUM_CH; c++) begin
          snap_q[c] <= val_flat[c*BIN_W +: BIN_W];
        end
      end
    end
  end

  assign conv_bin   = conv_q;
  assign digit      = digit_q;
  assign an         = an_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Scoreboard bench for bcd_scan_ctrl with NUM_CH=2, HOLD_CYC=4, active-low anodes.
module tb_bcd_scan_ctrl;

  localparam int NUM_CH   = 2;
  localparam int HOLD_CYC = 4;
  localparam int FRAME    = 2 * NUM_CH * (HOLD_CYC + 2);

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [11:0] val_flat;
  logic [5:0]  conv_bin;
  logic [3:0]  conv_tens;
  logic [3:0]  conv_units;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        frame_done;

  // Expected slot: [15:8] blank gap before it (0 = unchecked), [7:4] anode pattern, [3:0] digit.
  logic [15:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  int cycle = 0;
  int slot_starts = 0;
  int fd_count = 0;
  int fd_prev_cycle = 0;
  bit fd_prev_valid = 0;

  bcd_scan_ctrl #(
    .NUM_CH        (NUM_CH),
    .HOLD_CYC      (HOLD_CYC),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .val_flat   (val_flat),
    .conv_bin   (conv_bin),
    .conv_tens  (conv_tens),
    .conv_units (conv_units),
    .an         (an),
    .digit      (digit),
    .frame_done (frame_done)
  );

  // External converter model.
  assign conv_tens  = 4'(conv_bin / 6'd10);
  assign conv_units = 4'(conv_bin % 6'd10);

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver tasks
  task automatic push_slot(input logic [7:0] gap, input logic [3:0] a, input logic [3:0] d);
    exp_q.push_back({gap, a, d});
  endtask

  task automatic push_frame(input logic [7:0] g0, input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3);
    push_slot(g0,   4'b1110, d0);
    push_slot(8'd2, 4'b1101, d1);
    push_slot(8'd2, 4'b1011, d2);
    push_slot(8'd2, 4'b0111, d3);
  endtask

  task automatic wait_starts(input int n);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (slot_starts < n && k < 500);
    check("wait_slot_start", 32'(slot_starts >= n), 32'd1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_exp_q", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor / scoreboard
  bit         lit = 0;
  int         lit_len = 0;
  int         lit_gap = 0;
  int         blank_run = 0;
  logic [3:0] lit_an = 4'hF;
  logic [3:0] lit_digit = 4'h0;
  logic [3:0] prev_an = 4'hF;
  logic [5:0] prev_conv = 6'd0;
  bit         prev_rst = 1;

  always @(negedge clk) begin
    logic [15:0] e;
    bit cur_lit;
    cycle++;
    if (!rst_n) begin
      lit       = 0;
      blank_run = 0;
      prev_rst  = 1;
      prev_an   = 4'hF;
      prev_conv = conv_bin;
    end else begin
      cur_lit = (an != 4'hF);
      check("onehot_an", 32'($countones(~an) <= 1), 32'd1);
      if (conv_bin != prev_conv && !prev_rst)
        check("conv_bin_load_only", {30'd0, prev_an != 4'hF, cur_lit}, 32'd0);
      if (frame_done) begin
        fd_count++;
        check("frame_done_phase", 32'(prev_an), 32'h7);
        if (fd_prev_valid) check("frame_period", 32'(cycle - fd_prev_cycle), 32'(FRAME));
        fd_prev_cycle = cycle;
        fd_prev_valid = 1;
      end
      if (cur_lit && !lit) begin
        lit       = 1;
        lit_len   = 1;
        lit_an    = an;
        lit_digit = digit;
        lit_gap   = blank_run;
        blank_run = 0;
        slot_starts++;
      end else if (cur_lit) begin
        lit_len++;
        check("an_stable", 32'(an), 32'(lit_an));
        check("digit_stable", 32'(digit), 32'(lit_digit));
      end else begin
        if (lit) begin
          lit = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_slot: got an=%b digit=%0d required no lit slot", lit_an, lit_digit);
          end else begin
            e = exp_q.pop_front();
            check("slot_an", 32'(lit_an), 32'(e[7:4]));
            check("slot_digit", 32'(lit_digit), 32'(e[3:0]));
            check("slot_len", 32'(lit_len), 32'(HOLD_CYC));
            if (e[15:8] != 8'd0) check("slot_gap", 32'(lit_gap), 32'(e[15:8]));
          end
        end
        blank_run++;
      end
      prev_an   = an;
      prev_conv = conv_bin;
      prev_rst  = 0;
    end
  end

  // Stimulus
  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    val_flat = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_an", 32'(an), 32'hF);
    check("reset_digit", 32'(digit), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_conv_bin", 32'(conv_bin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three frames of 47/5, then 12 arrives mid-frame during slot 2 of frame 3.
    @(posedge clk);
    #1;
    val_flat = {6'd47, 6'd5};
    push_frame(8'd0, 4'd5, 4'd0, 4'd7, 4'd4);
    push_frame(8'd2, 4'd5, 4'd0, 4'd7, 4'd4);
    push_frame(8'd2, 4'd5, 4'd0, 4'd7, 4'd4);
    en = 1'b1;
    wait_starts(11);
    val_flat = {6'd12, 6'd5};
    push_frame(8'd2, 4'd5, 4'd0, 4'd2, 4'd1);

    // Boundary values 0 and 63.
    wait_starts(15);
    val_flat = {6'd63, 6'd0};
    push_frame(8'd2, 4'd0, 4'd0, 4'd3, 4'd6);
    push_slot(8'd2, 4'b1110, 4'd0);
    push_slot(8'd2, 4'b1101, 4'd0);

    // Drop en during slot 1: slot completes, then idle with no frame_done.
    wait_starts(22);
    en = 1'b0;
    wait_drain();
    repeat (10) @(posedge clk);
    #1;
    check("idle_an_blank", 32'(an), 32'hF);
    check("frame_done_count_a", 32'(fd_count), 32'd5);

    // Restart with a fresh snapshot: 20/9 -> 9,0,0,2.
    val_flat = {6'd20, 6'd9};
    fd_prev_valid = 0;
    push_frame(8'd0, 4'd9, 4'd0, 4'd0, 4'd2);
    en = 1'b1;

    // Reset mid-HOLD of the next frame's first slot.
    wait_starts(27);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_an", 32'(an), 32'hF);
    check("async_reset_digit", 32'(digit), 32'd0);
    check("async_reset_frame_done", 32'(frame_done), 32'd0);
    fd_prev_valid = 0;
    val_flat = {6'd47, 6'd5};
    push_frame(8'd0, 4'd5, 4'd0, 4'd7, 4'd4);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Stop during the last slot: no frame_done for the unfinished frame.
    wait_starts(31);
    en = 1'b0;
    wait_drain();
    repeat (10) @(posedge clk);
    #1;
    check("final_an_blank", 32'(an), 32'hF);
    check("frame_done_count_b", 32'(fd_count), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
